// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, status bit positions and address map.
// Used by the transmit FIFO block and the receive path.
package uart_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StStart = 2'd1,
      StData  = 2'd2,
      StStop  = 2'd3
   } uart_state_e;

   localparam int unsigned CNT_LSB   = 0;
   localparam int unsigned CNT_W     = 5;
   localparam int unsigned EMPTY_BIT = 8;
   localparam int unsigned FULL_BIT  = 9;
   localparam int unsigned BUSY_BIT  = 10;
   localparam int unsigned OVF_BIT   = 11;
   localparam int unsigned IRQEN_BIT = 12;

   localparam logic [31:0] UART_TX_BASE = 32'h0000_8014;
   localparam logic [31:0] UART_TX_LAST = 32'h0000_8017;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: baud counter, frame FSM and shift register.
// The line flop is updated from the current state, so each bit appears one cycle after entry.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 10
) (
   input  logic       clk_i,
   input  logic       reset,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   output logic       busy_o,
   output logic       tx_o
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntLoad = CntW'(CLKS_PER_BIT - 1);

   uart_state_e     r_state, w_state_d;
   logic [CntW-1:0] r_cnt, w_cnt_d;
   logic [2:0]      r_idx, w_idx_d;
   logic [7:0]      r_shift, w_shift_d;
   logic            r_tx, w_tx_d;
   logic            w_bit_done;

   assign w_bit_done = (r_cnt == '0);

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      w_idx_d   = r_idx;
      w_shift_d = r_shift;
      w_tx_d    = 1'b1;
      unique case (r_state)
         StIdle: begin
            if (start_i) begin
               w_state_d = StStart;
               w_cnt_d   = CntLoad;
               w_shift_d = byte_i;
            end
         end
         StStart: begin
            w_tx_d = 1'b0;
            if (w_bit_done) begin
               w_state_d = StData;
               w_cnt_d   = CntLoad;
               w_idx_d   = 3'd0;
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         StData: begin
            w_tx_d = r_shift[0];
            if (w_bit_done) begin
               w_cnt_d = CntLoad;
               if (r_idx == 3'd7) begin
                  w_state_d = StStop;
               end else begin
                  w_idx_d   = r_idx + 3'd1;
                  w_shift_d = {1'b0, r_shift[7:1]};
               end
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         StStop: begin
            w_tx_d = 1'b1;
            if (w_bit_done) begin
               w_state_d = StIdle;
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_shift <= 8'd0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
         r_idx   <= w_idx_d;
         r_shift <= w_shift_d;
         r_tx    <= w_tx_d;
      end
   end

   assign busy_o = (r_state != StIdle);
   assign tx_o   = r_tx;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bus-written byte FIFO feeding an 8N1 serializer, plus status word.
// Optional FIFO-drained interrupt enabled by defining UART_TX_IRQ_EN.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int unsigned SYS_CLK_FREQ = 100000000,
   parameter int unsigned BAUD         = 9600,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic        clk_i,
   input  logic        reset,
   input  logic        csb_i,
   input  logic        wen_i,
   input  logic [3:0]  wmask_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        tx_o,
   output logic        tx_irq_o
);

   localparam int unsigned CLKS_PER_BIT = SYS_CLK_FREQ / BAUD;
   localparam int unsigned PtrW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [PtrW-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic             w_wr, w_push_req, w_cfg_wr, w_push, w_pop;
   logic             w_full, w_empty, w_busy, w_ovf_set, w_ovf_clr;
   logic             w_irq_en;
   logic [31:0]      w_status;
   logic             w_unused;

   assign w_wr       = !csb_i && !wen_i;
   assign w_push_req = w_wr && wmask_i[0];
   assign w_cfg_wr   = w_wr && wmask_i[1];
   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   // Pop decision uses the registered count, so a push into an empty FIFO starts next cycle.
   assign w_pop      = !w_busy && !w_empty;
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_ovf_set  = w_push_req && w_full && !w_pop;
   assign w_ovf_clr  = w_cfg_wr && data_i[OVF_BIT];

   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= data_i[7:0];
      end
   end

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PtrW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
         if (w_ovf_clr) begin
            r_ovf <= 1'b0;
         end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
         end
      end
   end

`ifdef UART_TX_IRQ_EN
   logic r_irq_en;

   always_ff @(posedge clk_i or negedge reset) begin
      if (!reset) begin
         r_irq_en <= 1'b0;
      end else if (w_cfg_wr) begin
         r_irq_en <= data_i[IRQEN_BIT];
      end
   end

   assign w_irq_en = r_irq_en;
   assign tx_irq_o = r_irq_en && w_empty && !w_busy;
`else
   assign w_irq_en = 1'b0;
   assign tx_irq_o = 1'b0;
`endif

   always_comb begin
      w_status                     = '0;
      w_status[CNT_LSB +: CNT_W]   = r_count;
      w_status[EMPTY_BIT]          = w_empty;
      w_status[FULL_BIT]           = w_full;
      w_status[BUSY_BIT]           = w_busy;
      w_status[OVF_BIT]            = r_ovf;
      w_status[IRQEN_BIT]          = w_irq_en;
   end

   assign data_o = w_status;

   uart_tx_serializer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_serializer (
      .clk_i  (clk_i),
      .reset  (reset),
      .start_i(w_pop),
      .byte_i (r_mem[r_rd_ptr]),
      .busy_o (w_busy),
      .tx_o   (tx_o)
   );

   assign w_unused = ^{data_i[31:12], data_i[10:8], wmask_i[3:2]};

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: cycle-level FIFO/occupancy model plus a line decoder.
module tb_uart_tx_fifo;

   localparam int CPB   = 10;
   localparam int DEPTH = 16;
   localparam int FRAME = 10 * CPB;
`ifdef UART_TX_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        csb = 1'b1;
   logic        wen = 1'b1;
   logic [3:0]  wmask = 4'd0;
   logic [31:0] data_in = 32'd0;
   logic [31:0] data_out;
   logic        tx;
   logic        irq;

   int          total = 0;
   int          bad = 0;
   int unsigned cyc = 0;

   // Reference model state
   int          m_cnt = 0;
   int          m_left = 0;
   bit          m_ovf = 0;
   bit          m_en = 0;
   logic [7:0]  exp_q[$];
   int unsigned start_q[$];
   bit          rst_seen = 0;

   uart_tx_fifo #(
      .SYS_CLK_FREQ(1000000),
      .BAUD        (100000),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk_i   (clk),
      .reset   (rst_n),
      .csb_i   (csb),
      .wen_i   (wen),
      .wmask_i (wmask),
      .data_i  (data_in),
      .data_o  (data_out),
      .tx_o    (tx),
      .tx_irq_o(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_status();
      logic [31:0] st;
      logic [31:0] cnt_v;
      st       = 32'd0;
      cnt_v    = m_cnt;
      st[4:0]  = cnt_v[4:0];
      st[8]    = (m_cnt == 0);
      st[9]    = (m_cnt == DEPTH);
      st[10]   = (m_left > 0);
      st[11]   = m_ovf;
      st[12]   = IRQ_ON & m_en;
      return st;
   endfunction

   function automatic logic m_irq();
      return IRQ_ON & m_en & (m_cnt == 0) & (m_left == 0);
   endfunction

   task automatic m_reset();
      m_cnt  = 0;
      m_left = 0;
      m_ovf  = 0;
      m_en   = 0;
      exp_q.delete();
   endtask

   // One bus cycle; the model advances on the same edge and the status is compared after it.
   task automatic step(input logic c, input logic w, input logic [3:0] m, input logic [31:0] d);
      bit pop, req, cfg, was_full;
      csb = c; wen = w; wmask = m; data_in = d;
      pop      = (m_left == 0) && (m_cnt != 0);
      req      = !c && !w && m[0];
      cfg      = !c && !w && m[1];
      was_full = (m_cnt == DEPTH);
      @(posedge clk);
      #1;
      if (m_left > 0) m_left--;
      if (pop) m_left = FRAME;
      if (req && (!was_full || pop)) begin
         exp_q.push_back(d[7:0]);
         m_cnt++;
      end
      if (pop) m_cnt--;
      if (req && was_full && !pop) m_ovf = 1;
      if (cfg) begin
         if (d[11]) m_ovf = 0;
         m_en = d[12];
      end
      csb = 1'b1; wen = 1'b1; wmask = 4'd0; data_in = 32'd0;
      chk("status", data_out, m_status());
      chk("irq", {31'd0, irq}, {31'd0, m_irq()});
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b1, 4'd0, 32'd0);
   endtask

   task automatic wr(input logic [7:0] b);
      step(1'b0, 1'b0, 4'b0001, {24'd0, b});
   endtask

   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      rst_seen = 1;
      #1;
      chk("rst_tx_async", {31'd0, tx}, 32'd1);
      chk("rst_status", data_out, 32'h0000_0100);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Line decoder: samples each bit near its middle and checks bytes in posting order.
   initial begin
      logic [9:0]  bits;
      int unsigned t0;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n && tx === 1'b0) begin
            t0 = cyc;
            rst_seen = 0;
            repeat (4) @(posedge clk);
            #2;
            bits[0] = tx;
            for (int k = 1; k < 10; k++) begin
               repeat (10) @(posedge clk);
               #2;
               bits[k] = tx;
            end
            repeat (5) @(posedge clk);
            if (!rst_seen) begin
               start_q.push_back(t0);
               chk("start_bit", {31'd0, bits[0]}, 32'd0);
               chk("stop_bit", {31'd0, bits[9]}, 32'd1);
               chk("rx_pending", {31'd0, exp_q.size() != 0}, 32'd1);
               if (exp_q.size() != 0) begin
                  chk("rx_byte", {24'd0, bits[8:1]}, {24'd0, exp_q.pop_front()});
               end
            end
         end
      end
   end

   initial begin
      int unsigned c_push;
      int          n0;
      logic [7:0]  b;
      int          r;

      m_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_status", data_out, 32'h0000_0100);
      chk("reset_tx", {31'd0, tx}, 32'd1);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      rst_n = 1'b1;
      idle(3);

      // Single frame from idle: start bit two cycles after the push edge
      n0 = start_q.size();
      wr(8'h55);
      c_push = cyc;
      idle(FRAME + 10);
      chk("frames_55", start_q.size() - n0, 32'd1);
      if (start_q.size() > n0) chk("start_latency", start_q[n0] - c_push, 32'd2);

      // Back-to-back frames separated by a single idle cycle
      n0 = start_q.size();
      wr(8'h01);
      wr(8'h02);
      wr(8'h03);
      idle(3 * (FRAME + 1) + 10);
      chk("frames_b2b", start_q.size() - n0, 32'd3);
      if (start_q.size() >= n0 + 3) begin
         chk("gap_1_2", start_q[n0 + 1] - start_q[n0], FRAME + 1);
         chk("gap_2_3", start_q[n0 + 2] - start_q[n0 + 1], FRAME + 1);
      end

      // Fill boundary: 17 fits because the first byte pops, 18 overflows
      repeat (17) wr(8'($urandom));
      chk("ovf_17", {31'd0, data_out[11]}, 32'd0);
      idle(17 * (FRAME + 1) + 10);
      repeat (18) wr(8'($urandom));
      chk("ovf_18", {31'd0, data_out[11]}, 32'd1);
      chk("cnt_18", {27'd0, data_out[4:0]}, 32'd16);
      chk("full_18", {31'd0, data_out[9]}, 32'd1);
      step(1'b0, 1'b0, 4'b0010, 32'h0000_0800);
      chk("ovf_clr", {31'd0, data_out[11]}, 32'd0);
      idle(17 * (FRAME + 1) + 10);

      // Write while busy
      wr(8'h11);
      idle(3);
      wr(8'h22);
      chk("cnt_busy", {27'd0, data_out[4:0]}, 32'd1);
      idle(2 * (FRAME + 1) + 10);

      // Reset in the middle of the data bits
      wr(8'hA5);
      idle(40);
      n0 = start_q.size();
      do_reset();
      idle(FRAME + 30);
      chk("no_resume", start_q.size() - n0, 32'd0);
      chk("post_rst_status", data_out, 32'h0000_0100);

      // Interrupt enable and drain interrupt
      step(1'b0, 1'b0, 4'b0010, 32'h0000_1000);
      chk("irqen_rd", {31'd0, data_out[12]}, {31'd0, IRQ_ON});
      chk("irq_idle", {31'd0, irq}, {31'd0, IRQ_ON});
      wr(8'h7E);
      chk("irq_fall", {31'd0, irq}, 32'd0);
      idle(FRAME + 10);
      chk("irq_rise", {31'd0, irq}, {31'd0, IRQ_ON});

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 8) begin
            b = 8'($urandom);
            wr(b);
         end else if (r < 10) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), $urandom);
         end else begin
            idle(1);
         end
      end
      idle(17 * (FRAME + 1) + 20);
      chk("drained", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
